pcra_fetch_unit: RTL and testbench
==================================

# pcra_fetch_unit

Fetch-side address and bus-ownership controller for the CPU front end. Holds the two program-counter/return-address registers (PCRA0, PCRA1) and the flip flag that selects which one drives the fetch address. Sequences the `bus_request`/`fetch_suppress` pair consumed by pipeline stage 0, handing the bus to an external requester (DMA/device) without losing the in-flight instruction. Consumes stage 0's active-low `inc_pcra0`/`inc_pcra1` strobes.

## Interface
Parameters:
- `AWIDTH`, 16: width of PCRA registers and address bus.
- `RESET_VECTOR`, 16'h0000: PCRA0 value after reset.
- `MAX_GRANT`, 255: HOLD-cycle limit; used only with the watchdog compiled in.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inc_pcra0` in 1: active-low; PCRA0 += 1 at edge when 0.
- `inc_pcra1` in 1: active-low; PCRA1 += 1 at edge when 0.
- `load_pcra0` in 1: active-high; PCRA0 <= `addr_in`.
- `load_pcra1` in 1: active-high; PCRA1 <= `addr_in`.
- `addr_in` in AWIDTH: jump/return target.
- `toggle_flip` in 1: active-high; inverts `flag_pcraflip`.
- `dev_req` in 1: external bus request, level.
- `flag_pcraflip` out 1: 0 selects PCRA0, 1 selects PCRA1.
- `addr_out` out AWIDTH: selected PCRA.
- `addr_oe` out 1: fetch address drive enable.
- `bus_request` out 1: to stage 0.
- `fetch_suppress` out 1: to stage 0.
- `dev_grant` out 1: requester owns bus.
- `grant_timeout` out 1: sticky watchdog flag.

## Operation
- PCRA update per register, priority: load > increment > hold. Increment wraps all-ones -> 0. Both registers may update in the same cycle.
- `toggle_flip` is honoured in any state. `addr_out` is combinational from the post-edge registers: `flag_pcraflip ? PCRA1 : PCRA0`.
- Moore FSM with registered outputs (`bus_request`, `fetch_suppress`, `dev_grant`, `addr_oe`):
  - RUN (0,0,0,1): normal fetch. `dev_req`=1 -> GRANT.
  - GRANT (1,0,0,1): one cycle; stage 0 injects a NOP. `dev_req`=1 -> HOLD; `dev_req`=0 -> RELEASE (abort, no grant issued).
  - HOLD (1,1,1,0): stage 0 replays the held instruction. `dev_req`=0 -> RELEASE.
  - RELEASE (0,1,0,1): one cycle NOP while the address bus is re-driven; always -> RUN.
- `dev_req` is ignored in RELEASE. RUN lasts at least one cycle between grants.
- Reset mid-grant: immediate return to RUN values; `dev_grant` drops asynchronously.

## Timing
- Reset values: PCRA0=RESET_VECTOR, PCRA1=0, flip=0, state RUN, `bus_request`=0, `fetch_suppress`=0, `dev_grant`=0, `addr_oe`=1, `grant_timeout`=0, `addr_out`=RESET_VECTOR.
- `dev_req` sampled high at edge N: GRANT in cycle N+1, HOLD and `dev_grant`=1 from N+2.
- `dev_req` sampled low in HOLD at edge M: RELEASE in M+1, RUN in M+2.
- Increment and load: 1-cycle latency; the new `addr_out` is visible after the edge.

## Configuration
- `PCRA_FETCH_WATCHDOG_EN` defined: an 8+-bit counter clears on HOLD entry and counts HOLD cycles. On reaching MAX_GRANT, the FSM forces RELEASE and sets `grant_timeout` (sticky until `rst_n`). A new grant then requires `dev_req` to be observed low for at least one RUN cycle first.
- Not defined: HOLD persists indefinitely while `dev_req`=1; `grant_timeout` is tied 0; no counter logic.

## Test plan
- Reset: release `rst_n` -> `addr_out`=16'h0000, all handshake outputs 0, `addr_oe`=1. Then `inc_pcra0`=0 for 3 cycles -> `addr_out`=3.
- Wrap/priority: PCRA1=16'hFFFF, flip=1, `inc_pcra1`=0 -> `addr_out`=0. Then `load_pcra1`=1, `addr_in`=16'h1234 with `inc_pcra1`=0 -> 16'h1234.
- Grant cycle: `dev_req` 1 for 5 cycles then 0 -> (req,sup) sequence 00,10,11×n,01,00. `dev_grant` high only in HOLD; `addr_oe` low only in HOLD.
- Abort: `dev_req` high for exactly 1 cycle -> GRANT, RELEASE, RUN; `dev_grant` never asserts.
- Flip/simultaneous: `toggle_flip`=1 during HOLD with both incs asserted -> flip inverts, both PCRAs increment, and `addr_out` follows the new selection.
- Watchdog (macro on, MAX_GRANT=4): `dev_req` held 1 -> exactly 4 HOLD cycles, then RELEASE, `grant_timeout`=1. No regrant until `dev_req` drops; `rst_n` clears the flag.

Source files
------------

// File: rtl/pcra_fetch_unit.sv
// ---------------------------------------------------------------------------
// pcra_fetch_unit
// Fetch-side address and bus-ownership controller for the CPU front end.
// Holds the two program-counter/return-address registers (PCRA0, PCRA1) and
// the flip flag selecting which one drives the fetch address. Sequences the
// bus_request / fetch_suppress pair for pipeline stage 0 so an external
// requester can own the bus without losing the in-flight instruction.
//
// Optional feature: define PCRA_FETCH_WATCHDOG_EN to bound HOLD at MAX_GRANT
// cycles (forced RELEASE, sticky grant_timeout, regrant lockout until dev_req
// has been seen low in RUN). Without it HOLD lasts as long as dev_req does.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   inc_pcra0/1         active-low increment strobes from stage 0
//   load_pcra0/1        active-high load of addr_in (wins over increment)
//   addr_in             jump/return target
//   toggle_flip         invert flag_pcraflip
//   dev_req             external bus request (level)
//   flag_pcraflip       0: PCRA0 selected, 1: PCRA1 selected
//   addr_out            selected PCRA (combinational from the registers)
//   addr_oe             fetch address drive enable
//   bus_request         to stage 0
//   fetch_suppress      to stage 0
//   dev_grant           requester owns the bus
//   grant_timeout       sticky watchdog flag
// ---------------------------------------------------------------------------
module pcra_fetch_unit #(
  parameter int unsigned          AWIDTH       = 16,
  parameter logic [AWIDTH-1:0]    RESET_VECTOR = '0,
  parameter int unsigned          MAX_GRANT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_pcra0,
  input  logic              inc_pcra1,
  input  logic              load_pcra0,
  input  logic              load_pcra1,
  input  logic [AWIDTH-1:0] addr_in,
  input  logic              toggle_flip,
  input  logic              dev_req,
  output logic              flag_pcraflip,
  output logic [AWIDTH-1:0] addr_out,
  output logic              addr_oe,
  output logic              bus_request,
  output logic              fetch_suppress,
  output logic              dev_grant,
  output logic              grant_timeout
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] pcra0_q, pcra0_d;
  logic [AWIDTH-1:0] pcra1_q, pcra1_d;
  logic              flip_q, flip_d;
  logic              bus_request_q, bus_request_d;
  logic              fetch_suppress_q, fetch_suppress_d;
  logic              dev_grant_q, dev_grant_d;
  logic              addr_oe_q, addr_oe_d;

`ifdef PCRA_FETCH_WATCHDOG_EN
  localparam int unsigned CNT_W =
    ($clog2(MAX_GRANT + 1) > 8) ? $clog2(MAX_GRANT + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_q, lock_d;
  logic             timeout_q, timeout_d;
  logic             wd_fire;
`else
  // MAX_GRANT has no effect without the watchdog; referenced here only so
  // the parameter list stays identical between builds.
  if (MAX_GRANT == 0) begin : g_no_limit
  end
`endif

  // PCRA next values: load beats increment beats hold; increment wraps.
  always_comb begin : p_pcra
    pcra0_d = pcra0_q;
    pcra1_d = pcra1_q;
    if (load_pcra0) begin
      pcra0_d = addr_in;
    end else if (!inc_pcra0) begin
      pcra0_d = pcra0_q + AWIDTH'(1);
    end
    if (load_pcra1) begin
      pcra1_d = addr_in;
    end else if (!inc_pcra1) begin
      pcra1_d = pcra1_q + AWIDTH'(1);
    end
    flip_d = flip_q ^ toggle_flip;
  end

  // Bus-ownership next state.
  always_comb begin : p_next
    state_d = state_q;
`ifdef PCRA_FETCH_WATCHDOG_EN
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    wd_fire = 1'b0;
`endif
    unique case (state_q)
      ST_RUN: begin
`ifdef PCRA_FETCH_WATCHDOG_EN
        // After a timeout the requester must drop dev_req before regrant.
        if (!dev_req) begin
          lock_d = 1'b0;
        end else if (!lock_q) begin
          state_d = ST_GRANT;
        end
`else
        if (dev_req) begin
          state_d = ST_GRANT;
        end
`endif
      end
      ST_GRANT: begin
        state_d = dev_req ? ST_HOLD : ST_RELEASE;
`ifdef PCRA_FETCH_WATCHDOG_EN
        cnt_d = '0;
`endif
      end
      ST_HOLD: begin
        if (!dev_req) begin
          state_d = ST_RELEASE;
        end
`ifdef PCRA_FETCH_WATCHDOG_EN
        else begin
          // cnt_d is the number of HOLD cycles including this one.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d >= CNT_W'(MAX_GRANT)) begin
            state_d = ST_RELEASE;
            wd_fire = 1'b1;
            lock_d  = 1'b1;
          end
        end
`endif
      end
      ST_RELEASE: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  // Moore output decode from the next state, registered below.
  always_comb begin : p_out
    bus_request_d    = 1'b0;
    fetch_suppress_d = 1'b0;
    dev_grant_d      = 1'b0;
    addr_oe_d        = 1'b1;
    unique case (state_d)
      ST_RUN: ;
      ST_GRANT: bus_request_d = 1'b1;
      ST_HOLD: begin
        bus_request_d    = 1'b1;
        fetch_suppress_d = 1'b1;
        dev_grant_d      = 1'b1;
        addr_oe_d        = 1'b0;
      end
      ST_RELEASE: fetch_suppress_d = 1'b1;
      default: ;
    endcase
  end

`ifdef PCRA_FETCH_WATCHDOG_EN
  assign timeout_d = timeout_q | wd_fire;
`endif

  // State register; async reset drops dev_grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) begin
      state_q          <= ST_RUN;
      pcra0_q          <= RESET_VECTOR;
      pcra1_q          <= '0;
      flip_q           <= 1'b0;
      bus_request_q    <= 1'b0;
      fetch_suppress_q <= 1'b0;
      dev_grant_q      <= 1'b0;
      addr_oe_q        <= 1'b1;
    end else begin
      state_q          <= state_d;
      pcra0_q          <= pcra0_d;
      pcra1_q          <= pcra1_d;
      flip_q           <= flip_d;
      bus_request_q    <= bus_request_d;
      fetch_suppress_q <= fetch_suppress_d;
      dev_grant_q      <= dev_grant_d;
      addr_oe_q        <= addr_oe_d;
    end
  end

`ifdef PCRA_FETCH_WATCHDOG_EN
  // Watchdog counter, regrant lockout and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin : p_wd
    if (!rst_n) begin
      cnt_q     <= '0;
      lock_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_timeout = timeout_q;
`else
  assign grant_timeout = 1'b0;
`endif

  assign flag_pcraflip  = flip_q;
  assign addr_out       = flip_q ? pcra1_q : pcra0_q;
  assign addr_oe        = addr_oe_q;
  assign bus_request    = bus_request_q;
  assign fetch_suppress = fetch_suppress_q;
  assign dev_grant      = dev_grant_q;

endmodule

// File: tb/tb_pcra_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pcra_fetch_unit
// Scoreboard bench: the driver applies one cycle of stimulus at the falling
// edge, advances a behavioural model and queues the expected post-edge
// outputs; a monitor pops and compares after every rising edge.
// Watchdog scenarios are included when PCRA_FETCH_WATCHDOG_EN is defined.
// ---------------------------------------------------------------------------
module tb_pcra_fetch_unit;

  localparam int unsigned AW = 16;
  localparam logic [AW-1:0] RV = 16'h0000;
  localparam int unsigned MG = 4;
`ifdef PCRA_FETCH_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inc_pcra0, inc_pcra1, load_pcra0, load_pcra1;
  logic [AW-1:0] addr_in;
  logic          toggle_flip, dev_req;
  logic          flag_pcraflip, addr_oe, bus_request, fetch_suppress;
  logic          dev_grant, grant_timeout;
  logic [AW-1:0] addr_out;

  pcra_fetch_unit #(
    .AWIDTH(AW), .RESET_VECTOR(RV), .MAX_GRANT(MG)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .inc_pcra0(inc_pcra0), .inc_pcra1(inc_pcra1),
    .load_pcra0(load_pcra0), .load_pcra1(load_pcra1),
    .addr_in(addr_in), .toggle_flip(toggle_flip), .dev_req(dev_req),
    .flag_pcraflip(flag_pcraflip), .addr_out(addr_out), .addr_oe(addr_oe),
    .bus_request(bus_request), .fetch_suppress(fetch_suppress),
    .dev_grant(dev_grant), .grant_timeout(grant_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          flip, req, sup, gnt, oe, to;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: bus phase as a label, hold length, lockout, PC values.
  typedef enum int {P_RUN, P_GRANT, P_HOLD, P_RELEASE} phase_e;
  phase_e        m_phase;
  int            m_hold;
  bit            m_lock, m_to, m_flip;
  logic [AW-1:0] m_pc0, m_pc1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RUN; m_hold = 0; m_lock = 0; m_to = 0; m_flip = 0;
    m_pc0 = RV; m_pc1 = '0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.addr = m_flip ? m_pc1 : m_pc0;
    e.flip = m_flip;
    e.to   = m_to;
    e.req  = (m_phase == P_GRANT) || (m_phase == P_HOLD);
    e.sup  = (m_phase == P_HOLD) || (m_phase == P_RELEASE);
    e.gnt  = (m_phase == P_HOLD);
    e.oe   = (m_phase != P_HOLD);
    return e;
  endfunction

  task automatic model_step(input logic i0, i1, l0, l1, input logic [AW-1:0] a,
                            input logic t, d);
    if (l0) m_pc0 = a; else if (!i0) m_pc0 = m_pc0 + 1'b1;
    if (l1) m_pc1 = a; else if (!i1) m_pc1 = m_pc1 + 1'b1;
    if (t) m_flip = !m_flip;
    case (m_phase)
      P_RUN: begin
        if (!d) m_lock = 0;
        else if (!m_lock) m_phase = P_GRANT;
      end
      P_GRANT: begin
        m_phase = d ? P_HOLD : P_RELEASE;
        m_hold  = 0;
      end
      P_HOLD: begin
        if (!d) m_phase = P_RELEASE;
        else if (WD) begin
          m_hold++;
          if (m_hold >= int'(MG)) begin
            m_phase = P_RELEASE; m_to = 1; m_lock = 1;
          end
        end
      end
      default: m_phase = P_RUN;
    endcase
  endtask

  // One clock of stimulus plus its expected outcome.
  task automatic drive(input logic i0, i1, l0, l1, input logic [AW-1:0] a,
                       input logic t, d);
    @(negedge clk);
    inc_pcra0 = i0; inc_pcra1 = i1; load_pcra0 = l0; load_pcra1 = l1;
    addr_in = a; toggle_flip = t; dev_req = d;
    model_step(i0, i1, l0, l1, a, t, d);
    q.push_back(model_out());
  endtask

  task automatic idle(input int n, input logic d);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, d);
  endtask

  // Direct check of the reset-state outputs (no clock edge involved).
  task automatic check_reset_vals(input string tag);
    check({tag, "_addr_out"}, 32'(addr_out), 32'(RV));
    check({tag, "_flip"},     32'(flag_pcraflip), 32'd0);
    check({tag, "_req"},      32'(bus_request), 32'd0);
    check({tag, "_sup"},      32'(fetch_suppress), 32'd0);
    check({tag, "_grant"},    32'(dev_grant), 32'd0);
    check({tag, "_oe"},       32'(addr_oe), 32'd1);
    check({tag, "_timeout"},  32'(grant_timeout), 32'd0);
  endtask

  // Monitor: compare every post-edge output set against the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("addr_out",       32'(addr_out),       32'(e.addr));
        check("flag_pcraflip",  32'(flag_pcraflip),  32'(e.flip));
        check("bus_request",    32'(bus_request),    32'(e.req));
        check("fetch_suppress", 32'(fetch_suppress), 32'(e.sup));
        check("dev_grant",      32'(dev_grant),      32'(e.gnt));
        check("addr_oe",        32'(addr_oe),        32'(e.oe));
        check("grant_timeout",  32'(grant_timeout),  32'(e.to));
      end
    end
  end

  initial begin : stimulus
    logic d;
    rst_n = 1'b0;
    inc_pcra0 = 1'b1; inc_pcra1 = 1'b1; load_pcra0 = 1'b0; load_pcra1 = 1'b0;
    addr_in = '0; toggle_flip = 1'b0; dev_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_reset_vals("reset");

    // Three increments of PCRA0 -> 3.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Wrap and load-over-increment priority on PCRA1.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Full grant: dev_req high for 5 cycles, then low.
    idle(5, 1'b1);
    idle(4, 1'b0);

    // Abort: dev_req high for a single cycle.
    idle(1, 1'b1);
    idle(4, 1'b0);

    // Flip toggle and both increments during HOLD.
    idle(3, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(4, 1'b0);

    // Asynchronous reset while the requester owns the bus.
    idle(3, 1'b1);
    @(posedge clk);
    #3;
    check("pre_reset_grant", 32'(dev_grant), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    model_reset();
    dev_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1'b0);

`ifdef PCRA_FETCH_WATCHDOG_EN
    // Watchdog: dev_req stuck high, then dropped, then granted again.
    idle(12, 1'b1);
    idle(2, 1'b0);
    idle(6, 1'b1);
    idle(2, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1 check("wd_reset_clears_timeout", 32'(grant_timeout), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Randomised traffic with a slowly varying request.
    d = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) d = ~d;
      drive(($urandom_range(2) != 0), ($urandom_range(2) != 0),
            ($urandom_range(9) == 0), ($urandom_range(9) == 0),
            AW'($urandom), ($urandom_range(7) == 0), d);
    end
    idle(4, 1'b0);

    @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
